// File: rtl/aes_mask_prng_pkg.sv
// -----------------------------------------------------------------------------
// aes_mask_prng_pkg
//   Shared types and helpers for the AES masking PRNG.
//   - prng_state_e : control FSM states
//   - LFSR_WIDTH   : PRNG state width (taps below are only valid for 64)
//   - LFSR_TAPS    : feedback taps, bits 63, 62, 60, 59
//   - lfsr_advance : run the LFSR n single-bit steps
// -----------------------------------------------------------------------------
package aes_mask_prng_pkg;

  localparam int LFSR_WIDTH = 64;

  // Feedback bit = s[63] ^ s[62] ^ s[60] ^ s[59].
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Value loaded whenever an update would leave the LFSR in its dead state.
  localparam logic [LFSR_WIDTH-1:0] LFSR_ONE  = 64'h0000_0000_0000_0001;

  typedef enum logic [2:0] {
    UNSEEDED,
    LOAD,
    RUN,
    RESEED,
    HALT
  } prng_state_e;

  // Shift left n times, feeding the tap parity into bit 0. Called with a
  // constant n, so the loop unrolls into a pure XOR network.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(
    input logic [LFSR_WIDTH-1:0] state,
    input int                    n
  );
    logic [LFSR_WIDTH-1:0] s;
    s = state;
    for (int i = 0; i < n; i++) begin
      s = {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    end
    return s;
  endfunction

endpackage

// File: rtl/aes_mask_prng_lfsr.sv
// -----------------------------------------------------------------------------
// aes_mask_prng_lfsr
//   Combinational next-state datapath for the masking PRNG.
//   next_state = guard((advance ? adv(state) : state) ^ mix)
//   where adv() is MASK_WIDTH unrolled LFSR steps and guard() replaces an
//   all-zero result with 64'h1 so the LFSR can never lock up.
// Ports:
//   state      : current PRNG state
//   advance    : 1 = apply the MASK_WIDTH-step advance
//   mix        : value XORed in after the optional advance (seed material)
//   next_state : guarded result
// -----------------------------------------------------------------------------
module aes_mask_prng_lfsr
  import aes_mask_prng_pkg::*;
#(
  parameter int MASK_WIDTH = 26
) (
  input  logic [LFSR_WIDTH-1:0] state,
  input  logic                  advance,
  input  logic [LFSR_WIDTH-1:0] mix,
  output logic [LFSR_WIDTH-1:0] next_state
);

  logic [LFSR_WIDTH-1:0] stepped;
  logic [LFSR_WIDTH-1:0] mixed;

  always_comb begin
    stepped    = advance ? lfsr_advance(state, MASK_WIDTH) : state;
    mixed      = stepped ^ mix;
    next_state = (mixed == '0) ? LFSR_ONE : mixed;
  end

endmodule

// File: rtl/aes_mask_prng.sv
// -----------------------------------------------------------------------------
// aes_mask_prng
//   Masking-randomness source for the protected AES32 unit. A reseedable
//   64-bit LFSR delivers one fresh MASK_WIDTH-bit mask per transfer and asks
//   for fresh entropy every RESEED_INTERVAL masks without stalling delivery.
//
// Optional feature (macro AES_PRNG_HEALTH_EN):
//   repetition test on consecutive transferred masks; a repeat sets the sticky
//   health_err_o and parks the FSM in HALT until reset. Without the macro
//   health_err_o is tied to 0.
//
// Ports:
//   clk_i        : clock
//   rst_n        : asynchronous active-low reset
//   seed_valid_i : seed word valid
//   seed_ready_o : seed word accepted when valid && ready
//   seed_i       : seed word (two words form a full seed, low word first)
//   reseed_req_o : periodic reseed request
//   mask_valid_o : mask_o holds a fresh mask
//   mask_ready_i : consumer takes the mask (transfer = valid && ready)
//   mask_o       : state[MASK_WIDTH-1:0]
//   health_err_o : sticky health failure
// -----------------------------------------------------------------------------
module aes_mask_prng
  import aes_mask_prng_pkg::*;
#(
  parameter int MASK_WIDTH      = 26,
  parameter int SEED_WIDTH      = 32,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  seed_valid_i,
  output logic                  seed_ready_o,
  input  logic [SEED_WIDTH-1:0] seed_i,
  output logic                  reseed_req_o,
  output logic                  mask_valid_o,
  input  logic                  mask_ready_i,
  output logic [MASK_WIDTH-1:0] mask_o,
  output logic                  health_err_o
);

  localparam int                CNT_W   = $clog2(RESEED_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RESEED_INTERVAL);
  localparam int                HI_W    = LFSR_WIDTH - SEED_WIDTH;

  prng_state_e           fsm_q, fsm_d;
  logic [LFSR_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  seed_ready_d, mask_valid_d, reseed_req_d;

  logic                  seed_fire, mask_fire;
  logic                  use_lfsr, advance;
  logic [LFSR_WIDTH-1:0] mix, lfsr_next;
  logic                  rep_hit;

  assign seed_fire = seed_valid_i & seed_ready_o;
  // mask_ready_i only matters while a mask is offered.
  assign mask_fire = mask_valid_o & mask_ready_i;
  assign mask_o    = state_q[MASK_WIDTH-1:0];
  assign cnt_inc   = cnt_q + 1'b1;

  aes_mask_prng_lfsr #(
    .MASK_WIDTH (MASK_WIDTH)
  ) u_lfsr (
    .state      (state_q),
    .advance    (advance),
    .mix        (mix),
    .next_state (lfsr_next)
  );

`ifdef AES_PRNG_HEALTH_EN
  logic [MASK_WIDTH-1:0] last_mask_q;
  logic                  last_valid_q;
  logic                  health_err_q;

  assign rep_hit      = mask_fire & last_valid_q & (mask_o == last_mask_q);
  assign health_err_o = health_err_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      last_mask_q  <= '0;
      last_valid_q <= 1'b0;
      health_err_q <= 1'b0;
    end else if (mask_fire) begin
      last_mask_q  <= mask_o;
      last_valid_q <= 1'b1;
      if (rep_hit) health_err_q <= 1'b1;
    end
  end
`else
  assign rep_hit      = 1'b0;
  assign health_err_o = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    fsm_d    = fsm_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    use_lfsr = 1'b0;
    advance  = 1'b0;
    mix      = '0;

    unique case (fsm_q)
      UNSEEDED: begin
        if (seed_fire) begin
          // Low word is stored raw; the guard applies once the seed is whole.
          state_d = {state_q[LFSR_WIDTH-1:SEED_WIDTH], seed_i};
          fsm_d   = LOAD;
        end
      end
      LOAD: begin
        if (seed_fire) begin
          // XOR with the current high half so the result lands exactly on seed_i.
          mix      = {state_q[LFSR_WIDTH-1 -: SEED_WIDTH] ^ seed_i, {HI_W{1'b0}}};
          use_lfsr = 1'b1;
          fsm_d    = RUN;
        end
      end
      RUN: begin
        if (mask_fire) begin
          advance  = 1'b1;
          use_lfsr = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == CNT_MAX) fsm_d = RESEED;
        end
      end
      RESEED: begin
        // Masks keep flowing; the count stays parked at CNT_MAX until a seed.
        advance = mask_fire;
        if (seed_fire) begin
          mix      = {{HI_W{1'b0}}, seed_i};
          use_lfsr = 1'b1;
          cnt_d    = '0;
          fsm_d    = RUN;
        end else if (mask_fire) begin
          use_lfsr = 1'b1;
        end
      end
      default: begin
        // HALT: frozen until reset.
      end
    endcase

    if (use_lfsr) state_d = lfsr_next;
    if (rep_hit)  fsm_d   = HALT;

    // Outputs are registered from the next state so they all read 0 in reset.
    seed_ready_d = (fsm_d == UNSEEDED) || (fsm_d == LOAD) || (fsm_d == RESEED);
    mask_valid_d = (fsm_d == RUN) || (fsm_d == RESEED);
    reseed_req_d = (fsm_d == RESEED);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= UNSEEDED;
      state_q      <= '0;
      cnt_q        <= '0;
      seed_ready_o <= 1'b0;
      mask_valid_o <= 1'b0;
      reseed_req_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seed_ready_o <= seed_ready_d;
      mask_valid_o <= mask_valid_d;
      reseed_req_o <= reseed_req_d;
    end
  end

endmodule

// File: tb/tb_aes_mask_prng.sv
// -----------------------------------------------------------------------------
// tb_aes_mask_prng
//   Directed testbench for aes_mask_prng (RESEED_INTERVAL = 4). Inputs are
//   driven and outputs sampled on the falling clock edge. Health expectations
//   follow AES_PRNG_HEALTH_EN.
// -----------------------------------------------------------------------------
module tb_aes_mask_prng;

  localparam int MW = 26;
  localparam int SW = 32;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          seed_valid_i;
  logic          seed_ready_o;
  logic [SW-1:0] seed_i;
  logic          reseed_req_o;
  logic          mask_valid_o;
  logic          mask_ready_i;
  logic [MW-1:0] mask_o;
  logic          health_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  aes_mask_prng #(
    .MASK_WIDTH      (MW),
    .SEED_WIDTH      (SW),
    .RESEED_INTERVAL (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .seed_valid_i (seed_valid_i),
    .seed_ready_o (seed_ready_o),
    .seed_i       (seed_i),
    .reseed_req_o (reseed_req_o),
    .mask_valid_o (mask_valid_o),
    .mask_ready_i (mask_ready_i),
    .mask_o       (mask_o),
    .health_err_o (health_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: 26 single steps with feedback s63^s62^s60^s59, then xor, then guard.
  function automatic logic [63:0] ref_next(input logic [63:0] s, input logic adv,
                                           input logic [63:0] x);
    logic [63:0] r;
    r = s;
    if (adv) begin
      for (int i = 0; i < MW; i++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
    end
    r = r ^ x;
    if (r == 64'h0) r = 64'h1;
    return r;
  endfunction

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    seed_valid_i = 1'b0;
    seed_i       = '0;
    mask_ready_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_seed(input logic [31:0] lo, input logic [31:0] hi);
    seed_valid_i = 1'b1;
    seed_i       = lo;
    step();
    seed_i = hi;
    step();
    seed_valid_i = 1'b0;
    seed_i       = '0;
  endtask

  typedef struct {
    logic          sv;
    logic [31:0]   seed;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic          e_rq;
    logic [MW-1:0] e_mask;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] model;

  initial begin
    rst_n        = 1'b0;
    seed_valid_i = 1'b0;
    seed_i       = '0;
    mask_ready_i = 1'b0;

    // ---- reset state ----
    #2;
    check("rst seed_ready", 64'(seed_ready_o), 64'd0);
    check("rst mask_valid", 64'(mask_valid_o), 64'd0);
    check("rst reseed_req", 64'(reseed_req_o), 64'd0);
    check("rst mask", 64'(mask_o), 64'd0);
    check("rst health", 64'(health_err_o), 64'd0);

    // ---- test 1: zero seed forced to 1; ready ignored when not valid;
    //      seed ignored in RUN ----
    vecs[0] = '{1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 26'h0};
    vecs[1] = '{1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 26'h0};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 26'h1};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 26'h1};
    vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 26'h0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1[%0d] seed_ready", i), 64'(seed_ready_o), 64'(vecs[i].e_sr));
      check($sformatf("t1[%0d] mask_valid", i), 64'(mask_valid_o), 64'(vecs[i].e_mv));
      check($sformatf("t1[%0d] reseed_req", i), 64'(reseed_req_o), 64'(vecs[i].e_rq));
      check($sformatf("t1[%0d] mask", i), 64'(mask_o), 64'(vecs[i].e_mask));
      check($sformatf("t1[%0d] health", i), 64'(health_err_o), 64'd0);
      seed_valid_i = vecs[i].sv;
      seed_i       = vecs[i].seed;
      mask_ready_i = vecs[i].mr;
      step();
    end
    seed_valid_i = 1'b0;
    mask_ready_i = 1'b0;

    // ---- test 2: 8 back-to-back transfers ----
    do_reset();
    load_seed(32'hDEADBEEF, 32'h01234567);
    model = 64'h01234567_DEADBEEF;
    check("t2 first mask", 64'(mask_o), 64'h2ADBEEF);
    mask_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2[%0d] valid", i), 64'(mask_valid_o), 64'd1);
      check($sformatf("t2[%0d] mask", i), 64'(mask_o), 64'(model[MW-1:0]));
      step();
      model = ref_next(model, 1'b1, 64'h0);
    end
    mask_ready_i = 1'b0;

    // ---- test 3: reseed request after 4 transfers, seed with transfer ----
    do_reset();
    load_seed(32'h13579BDF, 32'h2468ACE0);
    model        = 64'h2468ACE0_13579BDF;
    mask_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3 pre[%0d] reseed_req", i), 64'(reseed_req_o), 64'd0);
      step();
      model = ref_next(model, 1'b1, 64'h0);
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t3 req[%0d] reseed_req", i), 64'(reseed_req_o), 64'd1);
      check($sformatf("t3 req[%0d] valid", i), 64'(mask_valid_o), 64'd1);
      check($sformatf("t3 req[%0d] mask", i), 64'(mask_o), 64'(model[MW-1:0]));
      step();
      model = ref_next(model, 1'b1, 64'h0);
    end
    check("t3 reseed seed_ready", 64'(seed_ready_o), 64'd1);
    seed_valid_i = 1'b1;
    seed_i       = 32'hA5A5A5A5;
    step();
    seed_valid_i = 1'b0;
    mask_ready_i = 1'b0;
    model = ref_next(model, 1'b1, 64'h00000000_A5A5A5A5);
    check("t3 post reseed_req", 64'(reseed_req_o), 64'd0);
    check("t3 post seed_ready", 64'(seed_ready_o), 64'd0);
    check("t3 post mask", 64'(mask_o), 64'(model[MW-1:0]));
    mask_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t3 count cleared", 64'(reseed_req_o), 64'd0);
    step();
    mask_ready_i = 1'b0;
    check("t3 second request", 64'(reseed_req_o), 64'd1);

    // ---- test 4: stall holds mask; reset mid-LOAD discards partial seed ----
    do_reset();
    load_seed(32'hCAFEF00D, 32'h0BADC0DE);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4 stall[%0d] mask", i), 64'(mask_o), 64'h2FEF00D);
      check($sformatf("t4 stall[%0d] valid", i), 64'(mask_valid_o), 64'd1);
      step();
    end
    do_reset();
    seed_valid_i = 1'b1;
    seed_i       = 32'h11111111;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t4 rst seed_ready", 64'(seed_ready_o), 64'd0);
    check("t4 rst mask_valid", 64'(mask_valid_o), 64'd0);
    check("t4 rst reseed_req", 64'(reseed_req_o), 64'd0);
    check("t4 rst mask", 64'(mask_o), 64'd0);
    check("t4 rst health", 64'(health_err_o), 64'd0);
    seed_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t4 unseeded seed_ready", 64'(seed_ready_o), 64'd1);
    check("t4 unseeded mask_valid", 64'(mask_valid_o), 64'd0);
    load_seed(32'h00000ABC, 32'h00000000);
    check("t4 fresh seed mask", 64'(mask_o), 64'hABC);
    check("t4 fresh seed valid", 64'(mask_valid_o), 64'd1);

    // ---- test 5: repetition test ----
    do_reset();
    load_seed(32'h0, 32'h0);
    mask_ready_i = 1'b1;
    check("t5 mask1", 64'(mask_o), 64'h1);
    step();
    check("t5 mask2", 64'(mask_o), 64'h0);
    check("t5 health2", 64'(health_err_o), 64'd0);
    step();
    check("t5 mask3", 64'(mask_o), 64'h0);
    check("t5 health3", 64'(health_err_o), 64'd0);
    step();
    mask_ready_i = 1'b0;
`ifdef AES_PRNG_HEALTH_EN
    check("t5 health set", 64'(health_err_o), 64'd1);
    check("t5 halt valid", 64'(mask_valid_o), 64'd0);
    check("t5 halt seed_ready", 64'(seed_ready_o), 64'd0);
    seed_valid_i = 1'b1;
    mask_ready_i = 1'b1;
    step();
    step();
    seed_valid_i = 1'b0;
    mask_ready_i = 1'b0;
    check("t5 health sticky", 64'(health_err_o), 64'd1);
    check("t5 halt held", 64'(mask_valid_o), 64'd0);
`else
    check("t5 health clear", 64'(health_err_o), 64'd0);
    check("t5 still valid", 64'(mask_valid_o), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_mask_prng.md
Name: aes_mask_prng

Overview:
Masking-randomness source for the protected AES32 functional unit inside the XIF AES wrapper. It replaces the constant randombits with a reseedable 64-bit LFSR stream. It delivers one fresh MASK_WIDTH-bit mask per accepted AES instruction over a valid/ready handshake. It requests entropy from an upstream seed source every RESEED_INTERVAL masks.

Parameters:
MASK_WIDTH, 26, width of each mask word delivered to the AES unit
LFSR_WIDTH, 64, PRNG state width; fixed at 64 (taps are defined for 64 only)
SEED_WIDTH, 32, width of one seed word; LFSR_WIDTH/SEED_WIDTH = 2 words per full seed
RESEED_INTERVAL, 1024, masks delivered before reseed_req_o asserts; must be >= 1

Ports:
clk_i  input  1  clock
rst_n  input  1  asynchronous active-low reset
seed_valid_i  input  1  seed word valid
seed_ready_o  output  1  seed word accepted when valid && ready
seed_i  input  SEED_WIDTH  seed word
reseed_req_o  output  1  periodic reseed requested
mask_valid_o  output  1  mask_o holds a fresh mask
mask_ready_i  input  1  consumer takes mask (transfer = valid && ready)
mask_o  output  MASK_WIDTH  mask, equal to state[MASK_WIDTH-1:0]
health_err_o  output  1  sticky health failure (see Optional Feature)

Behaviour:
- Reset value of every output is 0. Internal reset values: state = 64'h0, fsm = UNSEEDED, word count = 0, mask count = 0.
- LFSR step: nb = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], nb}. One advance = MASK_WIDTH steps unrolled in a single cycle.
- Zero guard: any state update that would produce 64'h0 loads 64'h1 instead.
- FSM states and transitions:
  - UNSEEDED: seed_ready_o = 1, mask_valid_o = 0. The first accepted word goes to state[31:0]; go to LOAD.
  - LOAD: seed_ready_o = 1. The accepted word goes to state[63:32], with the zero guard applied; go to RUN. mask_valid_o rises the cycle after this second word is accepted.
  - RUN: mask_valid_o = 1, seed_ready_o = 0. Each transfer advances the state and increments the mask count. The transfer that makes the count equal RESEED_INTERVAL goes to RESEED.
  - RESEED: reseed_req_o = 1, seed_ready_o = 1, mask_valid_o stays 1 (no stall).
    - On seed acceptance, state <= adv(state) ^ {32'h0, seed_i} if a transfer occurs in the same cycle, otherwise state ^ {32'h0, seed_i}; zero guard applies.
    - Mask count clears, reseed_req_o drops the next cycle, and the FSM returns to RUN.
    - Transfers in RESEED without a seed word advance the state normally. The mask count saturates at RESEED_INTERVAL.
- mask_o is combinationally state[MASK_WIDTH-1:0]. The mask is stable while mask_valid_o && !mask_ready_i.
- mask_ready_i is ignored while mask_valid_o = 0.
- Seed words are ignored (seed_ready_o = 0) in RUN.
- Asynchronous reset at any point returns to UNSEEDED and discards any partial seed.

Optional Feature:
Macro AES_PRNG_HEALTH_EN.
- With the macro:
  - A repetition test compares each transferred mask to the previously transferred mask. A register holds the last mask, reset to 0, with a valid flag.
  - On a match, health_err_o is set sticky, the FSM enters HALT (mask_valid_o = 0, seed_ready_o = 0), and the block stays there until reset.
- Without the macro: no comparison register and no HALT state; health_err_o is tied to 0.

Decomposition:
- aes_pkg additions:
  - prng_state_e {UNSEEDED, LOAD, RUN, RESEED, HALT}
  - LFSR_WIDTH localparam
  - LFSR tap constant
  - function lfsr_advance(state, n)
- Sub-module aes_prng_lfsr: combinational unrolled MASK_WIDTH-step advance plus the zero guard. The top level holds the FSM, counters and handshakes.

Test Plan:
1. Reset, then seed words 32'h0 and 32'h0: the state is forced to 64'h1. The first mask is 26'h0000001 and the second is 26'h0; seed_ready_o = 0 afterwards.
2. Seed 32'hDEADBEEF then 32'h01234567, 8 back-to-back transfers: mask_o matches the package-function reference model every cycle, and mask_valid_o is high continuously.
3. RESEED_INTERVAL = 4: reseed_req_o rises after the 4th transfer.
   - Transfers continue while no seed is given.
   - A seed 32'hA5A5A5A5 arriving simultaneously with a transfer produces adv(state) ^ 32'hA5A5A5A5, and reseed_req_o drops the next cycle.
4. mask_ready_i held low for 5 cycles with valid high: mask_o stays constant. rst_n is then pulsed mid-LOAD: all outputs are 0 and the FSM returns to UNSEEDED.
5. AES_PRNG_HEALTH_EN defined, seed 0/0: transfers give 1, 0, then 0 again. health_err_o asserts on the third transfer and mask_valid_o falls. The macro undefined gives health_err_o = 0 throughout.
